fifo_line_reader: RTL

- Read-side consumer of the 32-bit, 1k-deep video line FIFO in the MIPI-RX to parallel-TX path.
- Runs in the read clock domain. Drains the FIFO one 32-bit word per two pixels and unpacks each word into two 16-bit pixels.
- Generates parallel video timing (DE/HS/VS) from programmable parameters, and reports FIFO underflow.

---
 rtl/fifo_line_reader_pkg.sv | 45 ++++
 rtl/fifo_line_reader_if.sv | 24 ++
 rtl/video_timing_gen.sv | 66 ++++++
 rtl/fifo_line_reader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_line_reader_pkg.sv
// Shared types, colour-bar constants and timing helpers for fifo_line_reader.
// Optional test pattern is built when LINE_READER_TESTPAT_EN is defined.
package fifo_line_reader_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NUM_BARS = 8;

    localparam logic [15:0] BAR_0 = 16'hFFFF;
    localparam logic [15:0] BAR_1 = 16'hFFE0;
    localparam logic [15:0] BAR_2 = 16'h07FF;
    localparam logic [15:0] BAR_3 = 16'h07E0;
    localparam logic [15:0] BAR_4 = 16'hF81F;
    localparam logic [15:0] BAR_5 = 16'hF800;
    localparam logic [15:0] BAR_6 = 16'h001F;
    localparam logic [15:0] BAR_7 = 16'h0000;

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp,
                                    input int sync);
        return active + fp + sync;
    endfunction

    function automatic logic [15:0] bar_color(input int idx);
        logic [15:0] c;
        case (idx)
            0:       c = BAR_0;
            1:       c = BAR_1;
            2:       c = BAR_2;
            3:       c = BAR_3;
            4:       c = BAR_4;
            5:       c = BAR_5;
            6:       c = BAR_6;
            default: c = BAR_7;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fifo_line_reader_if.sv
// Read-side port bundle of the video line FIFO.
// master = FIFO, slave = line reader.
interface fifo_line_reader_if;

    logic [31:0] rdata;
    logic        rempty;
    logic        prog_empty;
    logic        ren;

    modport master (
        output rdata,
        output rempty,
        output prog_empty,
        input  ren
    );

    modport slave (
        input  rdata,
        input  rempty,
        input  prog_empty,
        output ren
    );

endinterface

// File: rtl/video_timing_gen.sv
// Horizontal/vertical raster counters with active, sync and end-of-frame decode.
// Counters sit at zero whenever run is low.
module video_timing_gen
    import fifo_line_reader_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hs,
    output logic             vs,
    output logic             eof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_S   = CNT_W'(sync_start(H_ACTIVE, H_FP));
    localparam logic [CNT_W-1:0] HS_E   = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CNT_W-1:0] VS_S   = CNT_W'(sync_start(V_ACTIVE, V_FP));
    localparam logic [CNT_W-1:0] VS_E   = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign eof    = h_last && v_last;

    // raster position: h wraps each line, v advances on every h wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs     = (h_cnt >= HS_S) && (h_cnt < HS_E);
    assign vs     = (v_cnt >= VS_S) && (v_cnt < VS_E);

endmodule

// File: rtl/fifo_line_reader.sv
// Drains the line FIFO, unpacks 32-bit words to 16-bit pixels, drives DE/HS/VS.
// Define LINE_READER_TESTPAT_EN to add the testpat_sel colour-bar source.
module fifo_line_reader
    import fifo_line_reader_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CNT_W    = 12
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                enable,
    fifo_line_reader_if.slave   fifo,
    output logic [15:0]         pix_data,
    output logic                pix_de,
    output logic                pix_hs,
    output logic                pix_vs,
    output logic                frame_start,
    output logic                underflow,
    input  logic                clr_underflow
`ifdef LINE_READER_TESTPAT_EN
    ,
    input  logic                testpat_sel
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic             run;
    logic             tp;
    logic             start_ok;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active;
    logic             hs;
    logic             vs;
    logic             eof;
    logic             slot;
    logic             uf_set;
    logic             sof;

    logic             de1;
    logic             hs1;
    logic             vs1;
    logic             fs1;
    logic             rd1;
    logic             odd1;
    logic [15:0]      hold;
    logic [15:0]      pix_next;

`ifdef LINE_READER_TESTPAT_EN
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / NUM_BARS);
    logic             tp1;
    logic [15:0]      bar1;
    assign tp = testpat_sel;
`else
    assign tp = 1'b0;
`endif

    assign run = (state_q == RUN);

    // the pattern source needs no FIFO fill level to start
    assign start_ok = enable && (!fifo.prog_empty || tp);

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CNT_W    (CNT_W)
    ) u_timing (
        .clk    (rclk),
        .rst_n  (rrst_n),
        .run    (run),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active),
        .hs     (hs),
        .vs     (vs),
        .eof    (eof)
    );

    // frame-level state register
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // start on enable with data ready; enable only re-checked at frame end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok)         state_d = RUN;
            RUN:     if (eof && !start_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // one FIFO word covers an even/odd pixel pair
    assign slot     = run && active && !h_cnt[0];
    assign fifo.ren = slot && !fifo.rempty && !tp;
    assign uf_set   = slot && fifo.rempty && !tp;
    assign sof      = run && (h_cnt == '0) && (v_cnt == '0);

    // stage 1: timing flags aligned with the FIFO read latency
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            de1  <= 1'b0;
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            fs1  <= 1'b0;
            rd1  <= 1'b0;
            odd1 <= 1'b0;
        end else begin
            de1  <= run && active;
            hs1  <= run && hs;
            vs1  <= run && vs;
            fs1  <= sof;
            rd1  <= fifo.ren;
            odd1 <= h_cnt[0];
        end
    end

`ifdef LINE_READER_TESTPAT_EN
    // stage 1: colour bar selected by horizontal position
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            tp1  <= 1'b0;
            bar1 <= '0;
        end else begin
            tp1  <= tp;
            bar1 <= bar_color(int'(h_cnt / BAR_W));
        end
    end
`endif

    // upper half-word waits one cycle; a missed read yields a zero pair
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n)            hold <= '0;
        else if (de1 && !odd1)  hold <= rd1 ? fifo.rdata[31:16] : 16'h0000;
    end

    // pixel source mux; blanking always shows zero
    always_comb begin
        pix_next = '0;
        if (de1) begin
            if (odd1)     pix_next = hold;
            else if (rd1) pix_next = fifo.rdata[15:0];
        end
`ifdef LINE_READER_TESTPAT_EN
        if (de1 && tp1) pix_next = bar1;
`endif
    end

    // stage 2: registered video outputs
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            pix_data    <= '0;
            pix_de      <= 1'b0;
            pix_hs      <= ~HS_POL;
            pix_vs      <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            pix_data    <= pix_next;
            pix_de      <= de1;
            pix_hs      <= hs1 ? HS_POL : ~HS_POL;
            pix_vs      <= vs1 ? VS_POL : ~VS_POL;
            frame_start <= fs1;
        end
    end

    // sticky underflow; a new event beats a same-cycle clear
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n)            underflow <= 1'b0;
        else if (uf_set)        underflow <= 1'b1;
        else if (clr_underflow) underflow <= 1'b0;
    end

endmodule
